// File: rtl/facto_bus_master_pkg.sv
// Shared definitions for the factorial-core bus master: register offsets, FSM states, data width.
package facto_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [15:0] OFS_OPERAND = 16'h0000;
  localparam logic [15:0] OFS_OPSTART = 16'h0008;
  localparam logic [15:0] OFS_OPCLEAR = 16'h0010;
  localparam logic [15:0] OFS_OPDONE  = 16'h0020;
  localparam logic [15:0] OFS_RES_H   = 16'h0028;
  localparam logic [15:0] OFS_RES_L   = 16'h0030;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_WR_OP,
    S_START,
    S_POLL,
    S_CHK,
    S_WAIT,
    S_RD_H,
    S_CAP_H,
    S_RD_L,
    S_CAP_L,
    S_ABORT,
    S_DONE
  } state_t;

  // 16-bit wrapping register address
  function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [15:0] ofs);
    return base + ofs;
  endfunction

endpackage

// File: rtl/facto_bus_master_if.sv
// Single-cycle slave bus between the master and the factorial core.
interface facto_bus_master_if;
  import facto_pkg::*;

  logic              s_sel;
  logic              s_wr;
  logic [15:0]       s_addr;
  logic [DATA_W-1:0] s_dout;
  logic [DATA_W-1:0] s_din;

  modport master (output s_sel, output s_wr, output s_addr, output s_dout, input  s_din);
  modport slave  (input  s_sel, input  s_wr, input  s_addr, input  s_dout, output s_din);

endinterface

// File: rtl/facto_bus_master.sv
// Drives the factorial core: clear, write operand, start, poll done, read 64-bit result.
// Optional poll timeout under FACTO_BUS_MASTER_TIMEOUT_EN.
module facto_bus_master
  import facto_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h7000,
  parameter int unsigned POLL_GAP  = 4
`ifdef FACTO_BUS_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TMO_LIMIT = 1023
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic [DATA_W-1:0]       operand,
  output logic                    busy,
  output logic                    res_valid,
  output logic [63:0]             result,
  output logic                    err,
  facto_bus_master_if.master      bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_busy;
  logic              r_res_valid;
  logic [63:0]       r_result;
  logic [DATA_W-1:0] r_operand;
  logic [7:0]        r_gap;

`ifdef FACTO_BUS_MASTER_TIMEOUT_EN
  localparam logic [9:0] TMO_CNT = 10'(TMO_LIMIT);
  logic [9:0] r_polls;
  logic       r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign result    = r_result;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (req) w_next = S_CLR;
      S_CLR:   w_next = S_WR_OP;
      S_WR_OP: w_next = S_START;
      S_START: w_next = S_POLL;
      S_POLL:  w_next = S_CHK;
      // CHK itself is the first idle cycle of the poll gap
      S_CHK: begin
        if (bus.s_din[0]) w_next = S_RD_H;
`ifdef FACTO_BUS_MASTER_TIMEOUT_EN
        else if (r_polls == TMO_CNT) w_next = S_ABORT;
`endif
        else if (POLL_GAP <= 1) w_next = S_POLL;
        else w_next = S_WAIT;
      end
      S_WAIT:  if (r_gap == 8'd0) w_next = S_POLL;
      S_RD_H:  w_next = S_CAP_H;
      S_CAP_H: w_next = S_RD_L;
      S_RD_L:  w_next = S_CAP_L;
      S_CAP_L: w_next = S_DONE;
      S_ABORT: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_result    <= '0;
      r_operand   <= '0;
      r_gap       <= '0;
      bus.s_sel   <= 1'b0;
      bus.s_wr    <= 1'b0;
      bus.s_addr  <= '0;
      bus.s_dout  <= '0;
`ifdef FACTO_BUS_MASTER_TIMEOUT_EN
      r_polls     <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state <= w_next;

      // Bus cycle is issued together with entry into its state
      bus.s_sel  <= 1'b0;
      bus.s_wr   <= 1'b0;
      bus.s_addr <= '0;
      bus.s_dout <= '0;
      unique case (w_next)
        S_CLR, S_ABORT: begin
          bus.s_sel <= 1'b1; bus.s_wr <= 1'b1;
          bus.s_addr <= reg_addr(BASE_ADDR, OFS_OPCLEAR); bus.s_dout <= DATA_W'(1);
        end
        S_WR_OP: begin
          bus.s_sel <= 1'b1; bus.s_wr <= 1'b1;
          bus.s_addr <= reg_addr(BASE_ADDR, OFS_OPERAND); bus.s_dout <= r_operand;
        end
        S_START: begin
          bus.s_sel <= 1'b1; bus.s_wr <= 1'b1;
          bus.s_addr <= reg_addr(BASE_ADDR, OFS_OPSTART); bus.s_dout <= DATA_W'(1);
        end
        S_POLL: begin
          bus.s_sel <= 1'b1; bus.s_addr <= reg_addr(BASE_ADDR, OFS_OPDONE);
        end
        S_RD_H: begin
          bus.s_sel <= 1'b1; bus.s_addr <= reg_addr(BASE_ADDR, OFS_RES_H);
        end
        S_RD_L: begin
          bus.s_sel <= 1'b1; bus.s_addr <= reg_addr(BASE_ADDR, OFS_RES_L);
        end
        default: ;
      endcase

      r_res_valid <= (w_next == S_DONE);

      if (r_state == S_IDLE && req) begin
        r_busy    <= 1'b1;
        r_operand <= operand;
`ifdef FACTO_BUS_MASTER_TIMEOUT_EN
        r_polls   <= '0;
        r_err     <= 1'b0;
`endif
      end
      if (w_next == S_DONE) r_busy <= 1'b0;

      if (r_state == S_CHK && w_next == S_WAIT) r_gap <= 8'(POLL_GAP - 2);
      else if (r_state == S_WAIT && r_gap != 8'd0) r_gap <= r_gap - 8'd1;

      if (r_state == S_CAP_H) r_result[63:32] <= bus.s_din;
      if (r_state == S_CAP_L) r_result[31:0]  <= bus.s_din;

`ifdef FACTO_BUS_MASTER_TIMEOUT_EN
      if (w_next == S_POLL) r_polls <= r_polls + 10'd1;
      if (r_state == S_ABORT) begin
        r_err    <= 1'b1;
        r_result <= '0;
      end
`endif
    end
  end

endmodule
